aquarium_sensor_scanner: RTL and testbench



---
 rtl/aquarium_pkg.sv | 36 +++
 rtl/aquarium_range_check.sv | 75 +++++++
 rtl/aquarium_sensor_scanner.sv | 172 +++++++++++++++++
 tb/tb_aquarium_sensor_scanner.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aquarium_pkg.sv
// ---------------------------------------------------------------------------
// aquarium_pkg
//
// Shared definitions for the aquarium monitor sensor scanner.
//
// Contents:
//   scan_state_t : scanner state machine encoding (IDLE, SCAN, HOLD)
//   CH_*         : fixed channel assignments for the tank sensors
//   ERR_PATTERN  : all-ones pattern driven on the scan outputs while frozen
//   dwell_width  : width helper for the per-channel dwell counter
// ---------------------------------------------------------------------------
package aquarium_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } scan_state_t;

  // Channel numbering used by the monitor firmware. Further channels are
  // appended after CH_SALT as sensors are added.
  localparam int CH_CLEAN = 0;
  localparam int CH_TEMP  = 1;
  localparam int CH_FOOD  = 2;
  localparam int CH_SALT  = 3;

  // Wide enough for any supported DATA_W / NUM_CH; users slice the low bits.
  localparam logic [63:0] ERR_PATTERN = '1;

  // A single-cycle dwell still needs a 1-bit counter so that the register
  // declaration stays legal.
  function automatic int dwell_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/aquarium_range_check.sv
// ---------------------------------------------------------------------------
// aquarium_range_check
//
// Storage and range supervision for one sensor channel. Holds the latest
// sample together with its low/high thresholds and raises a sticky alarm
// whenever the registered sample lies outside [lo, hi] (unsigned).
//
// Ports:
//   CLK        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   wr_en      : load wr_data into the sample register
//   wr_data    : new sample value
//   cfg_lo_en  : load cfg_data into the low threshold
//   cfg_hi_en  : load cfg_data into the high threshold
//   cfg_data   : new threshold value
//   alarm_clr  : clear the sticky alarm (a live violation still wins)
//   sample     : current sample register
//   alarm      : sticky out-of-range flag
// ---------------------------------------------------------------------------
module aquarium_range_check
  import aquarium_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cfg_lo_en,
  input  logic              cfg_hi_en,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              alarm_clr,
  output logic [DATA_W-1:0] sample,
  output logic              alarm
);

  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] hi;
  logic              out_of_range;

  // Thresholds reset to the widest possible window so that a freshly reset
  // channel never alarms.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sample <= '0;
      lo     <= '0;
      hi     <= '1;
    end else begin
      if (wr_en) begin
        sample <= wr_data;
      end
      if (cfg_lo_en) begin
        lo <= cfg_data;
      end
      if (cfg_hi_en) begin
        hi <= cfg_data;
      end
    end
  end

  // Evaluated on registered values only. An inverted window (lo > hi)
  // flags every sample, which is how firmware forces a channel into alarm.
  assign out_of_range = (sample < lo) || (sample > hi);

  // Set has priority over clear so a channel that is still bad cannot be
  // silenced by software.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      alarm <= 1'b0;
    end else begin
      alarm <= out_of_range || (alarm && !alarm_clr);
    end
  end

endmodule

// File: rtl/aquarium_sensor_scanner.sv
// ---------------------------------------------------------------------------
// aquarium_sensor_scanner
//
// Sensor register bank and scan multiplexer for the aquarium monitor. Each
// channel keeps one sample plus low/high thresholds in an
// aquarium_range_check slice. The scanner presents the channels one at a
// time on scan_data with a one-hot tag, dwelling SCAN_DIV cycles per
// channel. With FREEZE_ON_ALARM set, any alarm freezes the scanner in HOLD,
// where the outputs carry the all-ones error pattern until software clears
// the alarms.
//
// Parameters:
//   NUM_CH          : number of sensor channels (2..16)
//   DATA_W          : sample / threshold width
//   SCAN_DIV        : dwell cycles per channel (>= 1)
//   FREEZE_ON_ALARM : 1 = alarms force HOLD, 0 = alarms are only flagged
//   CH_W            : channel index width (derived)
//
// Ports:
//   CLK, reset_n    : clock (rising edge), asynchronous active-low reset
//   scan_en         : run the scanner
//   wr_en/wr_ch/wr_data        : sample write
//   cfg_en/cfg_hi/cfg_ch/cfg_data : threshold write (cfg_hi selects hi/lo)
//   alarm_clr       : clear all sticky alarms
//   scan_data       : presented sample
//   scan_ch         : one-hot tag of the presented channel
//   scan_valid      : one-cycle pulse when a channel is presented
//   alarm           : sticky per-channel out-of-range flags
//   error           : high while frozen in HOLD
// ---------------------------------------------------------------------------
module aquarium_sensor_scanner
  import aquarium_pkg::*;
#(
  parameter int  NUM_CH          = 4,
  parameter int  DATA_W          = 8,
  parameter int  SCAN_DIV        = 4,
  parameter int  FREEZE_ON_ALARM = 1,
  localparam int CH_W            = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              scan_en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              cfg_en,
  input  logic              cfg_hi,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              alarm_clr,
  output logic [DATA_W-1:0] scan_data,
  output logic [NUM_CH-1:0] scan_ch,
  output logic              scan_valid,
  output logic [NUM_CH-1:0] alarm,
  output logic              error
);

  localparam int              DIV_W      = dwell_width(SCAN_DIV);
  localparam logic [DIV_W-1:0] LAST_DWELL = DIV_W'(SCAN_DIV - 1);
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
  localparam bit               FREEZE     = (FREEZE_ON_ALARM != 0);

  scan_state_t                    state;
  logic [CH_W-1:0]                idx;
  logic [DIV_W-1:0]               dwell;
  logic [NUM_CH-1:0][DATA_W-1:0]  samples;
  logic                           wr_ok;
  logic                           cfg_ok;
  logic                           any_alarm;
  logic                           freeze_now;
  logic                           at_last_dwell;
  logic [CH_W-1:0]                idx_next;
  logic [NUM_CH-1:0]              idx_onehot;

  // When NUM_CH is not a power of two the index ports can name channels
  // that do not exist; such writes are dropped rather than aliased.
  assign wr_ok  = wr_en  && (int'(wr_ch)  < NUM_CH);
  assign cfg_ok = cfg_en && (int'(cfg_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;
    logic lo_sel;
    logic hi_sel;

    assign wr_sel = wr_ok  && (int'(wr_ch)  == i);
    assign lo_sel = cfg_ok && !cfg_hi && (int'(cfg_ch) == i);
    assign hi_sel = cfg_ok &&  cfg_hi && (int'(cfg_ch) == i);

    aquarium_range_check #(
      .DATA_W (DATA_W)
    ) u_chan (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .wr_en     (wr_sel),
      .wr_data   (wr_data),
      .cfg_lo_en (lo_sel),
      .cfg_hi_en (hi_sel),
      .cfg_data  (cfg_data),
      .alarm_clr (alarm_clr),
      .sample    (samples[i]),
      .alarm     (alarm[i])
    );
  end

  assign any_alarm     = |alarm;
  assign freeze_now    = FREEZE && any_alarm;
  assign at_last_dwell = (dwell == LAST_DWELL);
  assign idx_next      = (idx == LAST_CH) ? '0 : idx + CH_W'(1);
  assign idx_onehot    = NUM_CH'(1) << idx;

  // Scanner state machine and registered outputs.
  // HOLD entry is checked first so that it overrides both the IDLE/SCAN
  // handshake and the dwell progression. Leaving SCAN through scan_en=0
  // keeps idx and dwell, so a paused scan picks up where it stopped; only
  // the HOLD exit restarts the scan from channel 0.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      dwell      <= '0;
      scan_data  <= '0;
      scan_ch    <= '0;
      scan_valid <= 1'b0;
      error      <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      if ((state != HOLD) && freeze_now) begin
        state     <= HOLD;
        scan_data <= ERR_PATTERN[DATA_W-1:0];
        scan_ch   <= ERR_PATTERN[NUM_CH-1:0];
        error     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (scan_en) begin
              state <= SCAN;
            end
          end
          SCAN: begin
            if (!scan_en) begin
              state <= IDLE;
            end else begin
              if (dwell == '0) begin
                scan_data  <= samples[idx];
                scan_ch    <= idx_onehot;
                scan_valid <= 1'b1;
              end
              if (at_last_dwell) begin
                dwell <= '0;
                idx   <= idx_next;
              end else begin
                dwell <= dwell + DIV_W'(1);
              end
            end
          end
          HOLD: begin
            if (!any_alarm) begin
              error <= 1'b0;
              idx   <= '0;
              dwell <= '0;
              state <= scan_en ? SCAN : IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aquarium_sensor_scanner.sv
// ---------------------------------------------------------------------------
// tb_aquarium_sensor_scanner
//
// Two scanner instances share one clock:
//   dut_a : NUM_CH=4, SCAN_DIV=4, FREEZE_ON_ALARM=1
//   dut_b : NUM_CH=5, SCAN_DIV=2, FREEZE_ON_ALARM=0 (non power-of-two so
//           that nonexistent channel indices can be driven)
// Expected values come from per-channel sample/threshold arrays and the
// range rule "sample < lo or sample > hi"; scan order follows from the
// dwell length and the channel count.
// ---------------------------------------------------------------------------
module tb_aquarium_sensor_scanner;
  import aquarium_pkg::*;

  localparam int A_CH  = 4;
  localparam int A_DIV = 4;
  localparam int B_CH  = 5;
  localparam int B_DIV = 2;

  logic CLK;

  logic       a_rst_n, a_scan_en, a_wr_en, a_cfg_en, a_cfg_hi, a_alarm_clr;
  logic [1:0] a_wr_ch, a_cfg_ch;
  logic [7:0] a_wr_data, a_cfg_data, a_scan_data;
  logic [3:0] a_scan_ch, a_alarm;
  logic       a_scan_valid, a_error;

  logic       b_rst_n, b_scan_en, b_wr_en, b_cfg_en, b_cfg_hi, b_alarm_clr;
  logic [2:0] b_wr_ch, b_cfg_ch;
  logic [7:0] b_wr_data, b_cfg_data, b_scan_data;
  logic [4:0] b_scan_ch, b_alarm;
  logic       b_scan_valid, b_error;

  int vectors;
  int miscompares;

  logic [7:0] m_sample [A_CH];
  logic [7:0] m_lo     [A_CH];
  logic [7:0] m_hi     [A_CH];
  logic [7:0] bs       [B_CH];
  logic [7:0] blo      [B_CH];
  logic [7:0] bhi      [B_CH];

  aquarium_sensor_scanner #(
    .NUM_CH(A_CH), .DATA_W(8), .SCAN_DIV(A_DIV), .FREEZE_ON_ALARM(1)
  ) dut_a (
    .CLK(CLK), .reset_n(a_rst_n), .scan_en(a_scan_en),
    .wr_en(a_wr_en), .wr_ch(a_wr_ch), .wr_data(a_wr_data),
    .cfg_en(a_cfg_en), .cfg_hi(a_cfg_hi), .cfg_ch(a_cfg_ch), .cfg_data(a_cfg_data),
    .alarm_clr(a_alarm_clr), .scan_data(a_scan_data), .scan_ch(a_scan_ch),
    .scan_valid(a_scan_valid), .alarm(a_alarm), .error(a_error)
  );

  aquarium_sensor_scanner #(
    .NUM_CH(B_CH), .DATA_W(8), .SCAN_DIV(B_DIV), .FREEZE_ON_ALARM(0)
  ) dut_b (
    .CLK(CLK), .reset_n(b_rst_n), .scan_en(b_scan_en),
    .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_data(b_wr_data),
    .cfg_en(b_cfg_en), .cfg_hi(b_cfg_hi), .cfg_ch(b_cfg_ch), .cfg_data(b_cfg_data),
    .alarm_clr(b_alarm_clr), .scan_data(b_scan_data), .scan_ch(b_scan_ch),
    .scan_valid(b_scan_valid), .alarm(b_alarm), .error(b_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Safety net in case a wait is ever left unbounded.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [A_CH-1:0] a_out_of_range();
    logic [A_CH-1:0] v;
    v = '0;
    for (int i = 0; i < A_CH; i++) v[i] = (m_sample[i] < m_lo[i]) || (m_sample[i] > m_hi[i]);
    return v;
  endfunction

  function automatic logic [B_CH-1:0] b_out_of_range();
    logic [B_CH-1:0] v;
    v = '0;
    for (int i = 0; i < B_CH; i++) v[i] = (bs[i] < blo[i]) || (bs[i] > bhi[i]);
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic a_model_clear();
    for (int i = 0; i < A_CH; i++) begin
      m_sample[i] = 8'h00; m_lo[i] = 8'h00; m_hi[i] = 8'hFF;
    end
  endtask

  task automatic a_reset();
    a_rst_n = 1'b0; a_scan_en = 1'b0; a_wr_en = 1'b0; a_wr_ch = '0; a_wr_data = '0;
    a_cfg_en = 1'b0; a_cfg_hi = 1'b0; a_cfg_ch = '0; a_cfg_data = '0; a_alarm_clr = 1'b0;
    a_model_clear();
    tick();
    #3 a_rst_n = 1'b1;
    tick();
  endtask

  task automatic a_write(input logic [1:0] ch, input logic [7:0] data);
    a_wr_en = 1'b1; a_wr_ch = ch; a_wr_data = data;
    tick();
    a_wr_en = 1'b0;
    m_sample[ch] = data;
  endtask

  task automatic a_cfg(input logic [1:0] ch, input logic hi, input logic [7:0] data);
    a_cfg_en = 1'b1; a_cfg_hi = hi; a_cfg_ch = ch; a_cfg_data = data;
    tick();
    a_cfg_en = 1'b0;
    if (hi) m_hi[ch] = data; else m_lo[ch] = data;
  endtask

  task automatic b_reset();
    b_rst_n = 1'b0; b_scan_en = 1'b0; b_wr_en = 1'b0; b_wr_ch = '0; b_wr_data = '0;
    b_cfg_en = 1'b0; b_cfg_hi = 1'b0; b_cfg_ch = '0; b_cfg_data = '0; b_alarm_clr = 1'b0;
    for (int i = 0; i < B_CH; i++) begin
      bs[i] = 8'h00; blo[i] = 8'h00; bhi[i] = 8'hFF;
    end
    tick();
    #3 b_rst_n = 1'b1;
    tick();
  endtask

  // Channels >= B_CH do not exist, so the model is left untouched for them.
  task automatic b_write(input logic [2:0] ch, input logic [7:0] data);
    b_wr_en = 1'b1; b_wr_ch = ch; b_wr_data = data;
    tick();
    b_wr_en = 1'b0;
    if (int'(ch) < B_CH) bs[ch] = data;
  endtask

  task automatic b_cfg(input logic [2:0] ch, input logic hi, input logic [7:0] data);
    b_cfg_en = 1'b1; b_cfg_hi = hi; b_cfg_ch = ch; b_cfg_data = data;
    tick();
    b_cfg_en = 1'b0;
    if (int'(ch) < B_CH) begin
      if (hi) bhi[ch] = data; else blo[ch] = data;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    a_reset();
    vectors++; if (a_scan_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_scan_data got %h want 00", a_scan_data); end
    vectors++; if (a_scan_ch !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_scan_ch got %b want 0000", a_scan_ch); end
    vectors++; if (a_scan_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_scan_valid got %b want 0", a_scan_valid); end
    vectors++; if (a_alarm !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_alarm got %b want 0000", a_alarm); end
    vectors++; if (a_error !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_error got %b want 0", a_error); end
  endtask

  task automatic test_scan();
    logic       exp_valid;
    logic [3:0] exp_ch;
    logic [7:0] exp_data;
    int         pulses;
    for (int r = 0; r < 4; r++) begin
      a_reset();
      for (int c = 0; c < A_CH; c++) a_write(2'(c), (r == 0) ? 8'(8'h11 * (c + 1)) : 8'($urandom));
      a_scan_en = 1'b1;
      pulses = 0; exp_ch = '0; exp_data = '0;
      for (int cyc = 1; cyc <= 2 + A_DIV * A_CH; cyc++) begin
        tick();
        exp_valid = (cyc >= 2) && (((cyc - 2) % A_DIV) == 0);
        if (exp_valid) begin
          exp_ch   = 4'(1 << (pulses % A_CH));
          exp_data = m_sample[pulses % A_CH];
          pulses++;
        end
        vectors++; if (a_scan_valid !== exp_valid) begin miscompares++; $display("[TB] FAIL scan_valid r%0d cyc%0d got %b want %b", r, cyc, a_scan_valid, exp_valid); end
        vectors++; if (a_scan_ch !== exp_ch) begin miscompares++; $display("[TB] FAIL scan_ch r%0d cyc%0d got %b want %b", r, cyc, a_scan_ch, exp_ch); end
        vectors++; if (a_scan_data !== exp_data) begin miscompares++; $display("[TB] FAIL scan_data r%0d cyc%0d got %h want %h", r, cyc, a_scan_data, exp_data); end
      end
      vectors++; if (a_alarm !== a_out_of_range()) begin miscompares++; $display("[TB] FAIL scan_alarm r%0d got %b want %b", r, a_alarm, a_out_of_range()); end
      a_scan_en = 1'b0;
    end
  endtask

  task automatic test_alarm_freeze();
    a_reset();
    a_write(2'(CH_CLEAN), 8'($urandom));
    a_scan_en = 1'b1;
    a_cfg(2'(CH_TEMP), 1'b1, 8'h30);
    a_write(2'(CH_TEMP), 8'h31);
    vectors++; if (a_alarm !== 4'h0) begin miscompares++; $display("[TB] FAIL freeze_alarm_early got %b want 0000", a_alarm); end
    tick();
    vectors++; if (a_alarm !== a_out_of_range()) begin miscompares++; $display("[TB] FAIL freeze_alarm got %b want %b", a_alarm, a_out_of_range()); end
    vectors++; if (a_error !== 1'b0) begin miscompares++; $display("[TB] FAIL freeze_error_early got %b want 0", a_error); end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (a_error !== 1'b1) begin miscompares++; $display("[TB] FAIL freeze_error k%0d got %b want 1", k, a_error); end
      vectors++; if (a_scan_data !== 8'hFF) begin miscompares++; $display("[TB] FAIL freeze_scan_data k%0d got %h want ff", k, a_scan_data); end
      vectors++; if (a_scan_ch !== 4'hF) begin miscompares++; $display("[TB] FAIL freeze_scan_ch k%0d got %b want 1111", k, a_scan_ch); end
      vectors++; if (a_scan_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL freeze_scan_valid k%0d got %b want 0", k, a_scan_valid); end
    end
  endtask

  task automatic test_hold_clear();
    logic [3:0] held;
    a_alarm_clr = 1'b1; tick(); a_alarm_clr = 1'b0;
    vectors++; if (a_alarm !== a_out_of_range()) begin miscompares++; $display("[TB] FAIL clear_set_wins got %b want %b", a_alarm, a_out_of_range()); end
    vectors++; if (a_error !== 1'b1) begin miscompares++; $display("[TB] FAIL clear_still_hold got %b want 1", a_error); end
    held = a_out_of_range();
    a_write(2'(CH_TEMP), 8'($urandom_range(0, 8'h30)));
    tick();
    vectors++; if (a_alarm !== held) begin miscompares++; $display("[TB] FAIL clear_sticky got %b want %b", a_alarm, held); end
    a_alarm_clr = 1'b1; tick(); a_alarm_clr = 1'b0;
    vectors++; if (a_alarm !== 4'h0) begin miscompares++; $display("[TB] FAIL clear_alarm got %b want 0000", a_alarm); end
    vectors++; if (a_error !== 1'b1) begin miscompares++; $display("[TB] FAIL clear_error_n got %b want 1", a_error); end
    tick();
    vectors++; if (a_error !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_exit_error got %b want 0", a_error); end
    vectors++; if (a_scan_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL clear_exit_valid got %b want 0", a_scan_valid); end
    tick();
    vectors++; if (a_scan_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_valid got %b want 1", a_scan_valid); end
    vectors++; if (a_scan_ch !== 4'(1 << CH_CLEAN)) begin miscompares++; $display("[TB] FAIL restart_ch got %b want 0001", a_scan_ch); end
    vectors++; if (a_scan_data !== m_sample[CH_CLEAN]) begin miscompares++; $display("[TB] FAIL restart_data got %h want %h", a_scan_data, m_sample[CH_CLEAN]); end
    a_scan_en = 1'b0;
  endtask

  task automatic test_pause();
    logic [7:0] frozen;
    bit         seen;
    a_reset();
    for (int c = 0; c < A_CH; c++) a_write(2'(c), 8'($urandom));
    a_scan_en = 1'b1;
    repeat (6) tick();
    vectors++; if (a_scan_ch !== 4'(1 << CH_TEMP) || a_scan_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL pause_pre got ch %b valid %b want 0010 1", a_scan_ch, a_scan_valid); end
    frozen = m_sample[CH_TEMP];
    repeat ($urandom_range(0, 2)) tick();
    a_scan_en = 1'b0;
    tick();
    a_write(2'(CH_TEMP), ~frozen);
    for (int k = 0; k < 5; k++) begin
      vectors++; if (a_scan_valid !== 1'b0 || a_scan_ch !== 4'(1 << CH_TEMP) || a_scan_data !== frozen) begin
        miscompares++; $display("[TB] FAIL pause_frozen k%0d got %b/%b/%h want 0/0010/%h", k, a_scan_valid, a_scan_ch, a_scan_data, frozen);
      end
      tick();
    end
    a_scan_en = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < A_DIV + 4 && !seen; k++) begin
      tick();
      if (a_scan_valid === 1'b1) begin
        seen = 1'b1;
        vectors++; if (a_scan_ch !== 4'(1 << CH_FOOD) || a_scan_data !== m_sample[CH_FOOD]) begin
          miscompares++; $display("[TB] FAIL resume_next got %b/%h want 0100/%h", a_scan_ch, a_scan_data, m_sample[CH_FOOD]);
        end
      end
    end
    if (!seen) begin vectors++; miscompares++; $display("[TB] FAIL resume_timeout got no scan_valid want one"); end
    a_scan_en = 1'b0;
  endtask

  task automatic test_async_reset();
    a_reset();
    a_cfg(2'(CH_CLEAN), 1'b0, 8'h20);
    a_cfg(2'(CH_TEMP), 1'b1, 8'h30);
    a_write(2'(CH_CLEAN), 8'($urandom_range(8'h20, 8'hFF)));
    a_write(2'(CH_TEMP), 8'($urandom_range(0, 8'h30)));
    a_scan_en = 1'b1;
    repeat (7) tick();
    vectors++; if (a_scan_ch === 4'h0) begin miscompares++; $display("[TB] FAIL midscan_pre got ch %b want nonzero", a_scan_ch); end
    #3 a_rst_n = 1'b0; a_scan_en = 1'b0; a_model_clear();
    #1;
    vectors++; if ({a_scan_data, a_scan_ch, a_scan_valid, a_alarm, a_error} !== 18'h0) begin
      miscompares++; $display("[TB] FAIL async_midscan got %h/%b/%b/%b/%b want all zero", a_scan_data, a_scan_ch, a_scan_valid, a_alarm, a_error);
    end
    tick();
    #3 a_rst_n = 1'b1;
    tick();
    a_write(2'(CH_CLEAN), 8'h00);
    a_write(2'(CH_TEMP), 8'hFF);
    tick();
    vectors++; if (a_alarm !== a_out_of_range()) begin miscompares++; $display("[TB] FAIL thresholds_reset got %b want %b", a_alarm, a_out_of_range()); end
    a_cfg(2'(CH_FOOD), 1'b1, 8'h10);
    a_write(2'(CH_FOOD), 8'h50);
    tick(); tick();
    vectors++; if (a_error !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_pre got %b want 1", a_error); end
    #3 a_rst_n = 1'b0; a_model_clear();
    #1;
    vectors++; if ({a_scan_data, a_scan_ch, a_scan_valid, a_alarm, a_error} !== 18'h0) begin
      miscompares++; $display("[TB] FAIL async_hold got %h/%b/%b/%b/%b want all zero", a_scan_data, a_scan_ch, a_scan_valid, a_alarm, a_error);
    end
    tick();
    #3 a_rst_n = 1'b1;
    tick();
    a_write(2'(CH_FOOD), 8'h50);
    tick(); tick();
    vectors++; if (a_alarm !== a_out_of_range() || a_error !== 1'b0) begin
      miscompares++; $display("[TB] FAIL hold_thresholds_reset got %b/%b want %b/0", a_alarm, a_error, a_out_of_range());
    end
  endtask

  task automatic test_freeze_off();
    logic       exp_valid;
    logic [4:0] exp_ch;
    logic [7:0] exp_data, lo_v;
    int         pulses;
    b_reset();
    lo_v = 8'($urandom_range(16, 128));
    for (int c = 0; c < B_CH; c++) if (c != CH_SALT) b_write(3'(c), 8'($urandom));
    b_cfg(3'(CH_SALT), 1'b0, lo_v);
    b_write(3'(CH_SALT), 8'($urandom_range(0, int'(lo_v) - 1)));
    tick();
    vectors++; if (b_alarm !== b_out_of_range()) begin miscompares++; $display("[TB] FAIL nofreeze_alarm got %b want %b", b_alarm, b_out_of_range()); end
    b_scan_en = 1'b1;
    pulses = 0; exp_ch = '0; exp_data = '0;
    for (int cyc = 1; cyc <= 2 + B_DIV * (B_CH + 1); cyc++) begin
      tick();
      exp_valid = (cyc >= 2) && (((cyc - 2) % B_DIV) == 0);
      if (exp_valid) begin
        exp_ch   = 5'(1 << (pulses % B_CH));
        exp_data = bs[pulses % B_CH];
        pulses++;
      end
      vectors++; if (b_error !== 1'b0) begin miscompares++; $display("[TB] FAIL nofreeze_error cyc%0d got %b want 0", cyc, b_error); end
      vectors++; if (b_scan_valid !== exp_valid || b_scan_ch !== exp_ch || b_scan_data !== exp_data) begin
        miscompares++; $display("[TB] FAIL nofreeze_scan cyc%0d got %b/%b/%h want %b/%b/%h", cyc, b_scan_valid, b_scan_ch, b_scan_data, exp_valid, exp_ch, exp_data);
      end
    end
    vectors++; if (b_alarm !== b_out_of_range()) begin miscompares++; $display("[TB] FAIL nofreeze_alarm_end got %b want %b", b_alarm, b_out_of_range()); end
    b_scan_en = 1'b0;
  endtask

  task automatic test_out_of_range_write();
    logic       exp_valid;
    logic [4:0] exp_ch;
    logic [7:0] exp_data;
    int         pulses;
    b_reset();
    for (int c = 0; c < B_CH; c++) b_write(3'(c), 8'($urandom));
    for (int c = B_CH; c < 8; c++) begin
      b_write(3'(c), 8'($urandom));
      b_cfg(3'(c), 1'b0, 8'hFF);
      b_cfg(3'(c), 1'b1, 8'h00);
    end
    tick();
    vectors++; if (b_alarm !== b_out_of_range()) begin miscompares++; $display("[TB] FAIL oor_alarm got %b want %b", b_alarm, b_out_of_range()); end
    b_scan_en = 1'b1;
    pulses = 0; exp_ch = '0; exp_data = '0;
    for (int cyc = 1; cyc <= 2 + B_DIV * (B_CH - 1); cyc++) begin
      tick();
      exp_valid = (cyc >= 2) && (((cyc - 2) % B_DIV) == 0);
      if (exp_valid) begin
        exp_ch   = 5'(1 << (pulses % B_CH));
        exp_data = bs[pulses % B_CH];
        pulses++;
        vectors++; if (b_scan_valid !== 1'b1 || b_scan_ch !== exp_ch || b_scan_data !== exp_data) begin
          miscompares++; $display("[TB] FAIL oor_scan cyc%0d got %b/%b/%h want 1/%b/%h", cyc, b_scan_valid, b_scan_ch, b_scan_data, exp_ch, exp_data);
        end
      end
    end
    b_scan_en = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    b_rst_n = 1'b0; b_scan_en = 1'b0; b_wr_en = 1'b0; b_wr_ch = '0; b_wr_data = '0;
    b_cfg_en = 1'b0; b_cfg_hi = 1'b0; b_cfg_ch = '0; b_cfg_data = '0; b_alarm_clr = 1'b0;
    test_reset();
    test_scan();
    test_alarm_freeze();
    test_hold_clear();
    test_pause();
    test_async_reset();
    test_freeze_off();
    test_out_of_range_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
